tcam_lookup_engine: RTL and testbench

//  Self-contained parametrised TCAM with a valid/ready command port and a valid/ready response port.

---
 rtl/tcam_lookup_engine.sv | 162 ++++++++++++++++
 tb/tb_tcam_lookup_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_lookup_engine.sv
// Parametrised TCAM: write/read/flush/masked-lookup over WORDS entries, one command in flight,
// lowest-index hit wins, with saturating lookup/hit statistics.
module tcam_lookup_engine #(
  parameter int KEY_W  = 8,
  parameter int ID_W   = 4,
  parameter int WORDS  = 16,
  parameter int ADDR_W = $clog2(WORDS),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [KEY_W-1:0]  cmd_mask,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic              cmd_vld,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_index,
  output logic [ID_W-1:0]   rsp_id,
  output logic [KEY_W-1:0]  rsp_key,
  output logic [KEY_W-1:0]  rsp_mask,
  output logic [CNT_W-1:0]  lookup_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_LOOKUP = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t state_q, state_d;

  logic [KEY_W-1:0]  key_q  [WORDS];
  logic [KEY_W-1:0]  mask_q [WORDS];
  logic [ID_W-1:0]   id_q   [WORDS];
  logic [WORDS-1:0]  vld_q;

  logic [KEY_W-1:0]  lkey_q;
  logic              rsp_hit_q;
  logic [ADDR_W-1:0] rsp_index_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [KEY_W-1:0]  rsp_key_q;
  logic [KEY_W-1:0]  rsp_mask_q;
  logic [CNT_W-1:0]  lookup_cnt_q;
  logic [CNT_W-1:0]  hit_cnt_q;

  logic              accept;
  logic              addr_ok;
  logic              any_hit;
  logic [ADDR_W-1:0] hit_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // cmd_ready is held low while reset is asserted, even though the state register already reads IDLE.
  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  generate
    if (WORDS == (1 << ADDR_W)) begin : g_full_addr
      assign addr_ok = 1'b1;
    end else begin : g_part_addr
      assign addr_ok = ({1'b0, cmd_addr} < (ADDR_W + 1)'(WORDS));
    end
  endgenerate

  // Downward scan so the lowest matching index is the one left standing.
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (vld_q[i] && (((lkey_q ^ key_q[i]) & mask_q[i]) == '0)) begin
        any_hit = 1'b1;
        hit_idx = ADDR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_op == OP_READ)   state_d = S_RESP;
        if (accept && cmd_op == OP_LOOKUP) state_d = S_CMP;
      end
      S_CMP:  state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        key_q[i]  <= '0;
        mask_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else if (accept && cmd_op == OP_WRITE && addr_ok) begin
      key_q[cmd_addr]  <= cmd_key;
      mask_q[cmd_addr] <= cmd_mask;
      id_q[cmd_addr]   <= cmd_id;
      vld_q[cmd_addr]  <= cmd_vld;
    end else if (accept && cmd_op == OP_FLUSH) begin
      vld_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lkey_q       <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_index_q  <= '0;
      rsp_id_q     <= '0;
      rsp_key_q    <= '0;
      rsp_mask_q   <= '0;
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      if (accept && cmd_op == OP_LOOKUP) lkey_q <= cmd_key;
      if (accept && cmd_op == OP_READ) begin
        rsp_hit_q   <= addr_ok ? vld_q[cmd_addr]  : 1'b0;
        rsp_index_q <= addr_ok ? cmd_addr         : '0;
        rsp_id_q    <= addr_ok ? id_q[cmd_addr]   : '0;
        rsp_key_q   <= addr_ok ? key_q[cmd_addr]  : '0;
        rsp_mask_q  <= addr_ok ? mask_q[cmd_addr] : '0;
      end else if (state_q == S_CMP) begin
        rsp_hit_q    <= any_hit;
        rsp_index_q  <= any_hit ? hit_idx : '0;
        rsp_id_q     <= any_hit ? id_q[hit_idx] : '0;
        rsp_key_q    <= '0;
        rsp_mask_q   <= '0;
        lookup_cnt_q <= sat_inc(lookup_cnt_q);
        if (any_hit) hit_cnt_q <= sat_inc(hit_cnt_q);
      end
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_hit    = rsp_hit_q;
  assign rsp_index  = rsp_index_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_key    = rsp_key_q;
  assign rsp_mask   = rsp_mask_q;
  assign lookup_cnt = lookup_cnt_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// Scoreboard bench for tcam_lookup_engine: directed commands push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_tcam_lookup_engine;

  localparam int KEY_W  = 8;
  localparam int ID_W   = 4;
  localparam int WORDS  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_LOOKUP = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [KEY_W-1:0]  cmd_key;
  logic [KEY_W-1:0]  cmd_mask;
  logic [ID_W-1:0]   cmd_id;
  logic              cmd_vld;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [ADDR_W-1:0] rsp_index;
  logic [ID_W-1:0]   rsp_id;
  logic [KEY_W-1:0]  rsp_key;
  logic [KEY_W-1:0]  rsp_mask;
  logic [CNT_W-1:0]  lookup_cnt;
  logic [CNT_W-1:0]  hit_cnt;

  tcam_lookup_engine #(
    .KEY_W(KEY_W), .ID_W(ID_W), .WORDS(WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask), .cmd_id(cmd_id), .cmd_vld(cmd_vld),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
    .rsp_id(rsp_id), .rsp_key(rsp_key), .rsp_mask(rsp_mask),
    .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic [ID_W-1:0]   id;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic h, input logic [ADDR_W-1:0] i, input logic [ID_W-1:0] d,
                              input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] m);
    exp_t e;
    e.hit = h; e.idx = i; e.id = d; e.key = k; e.mask = m;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got hit=%0b idx=%0d id=%0d, no response expected",
                 rsp_hit, rsp_index, rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp{hit,idx,id,key,mask}", 32'({rsp_hit, rsp_index, rsp_id, rsp_key, rsp_mask}),
            32'({e.hit, e.idx, e.id, e.key, e.mask}));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] k,
                       input logic [KEY_W-1:0] m, input logic [ID_W-1:0] d, input logic v);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_key = k; cmd_mask = m; cmd_id = d; cmd_vld = v;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_done();
    int n;
    n = 0;
    while (rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid) chk("rsp_drain_timeout", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] k,
                          input logic [KEY_W-1:0] m, input logic [ID_W-1:0] d, input logic v);
    issue(OP_WRITE, a, k, m, d, v);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input exp_t e);
    sb.push_back(e);
    issue(OP_READ, a, '0, '0, '0, 1'b0);
    chk("read_latency1", 32'(rsp_valid), 32'd1);
    wait_rsp_done();
  endtask

  task automatic do_lookup(input logic [KEY_W-1:0] k, input exp_t e);
    sb.push_back(e);
    issue(OP_LOOKUP, '0, k, '0, '0, 1'b0);
    chk("lookup_cyc1_not_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lookup_latency2", 32'(rsp_valid), 32'd1);
    wait_rsp_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] snap;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_key = '0;
    cmd_mask = '0; cmd_id = '0; cmd_vld = 1'b0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    chk("counters_after_reset", 32'({lookup_cnt, hit_cnt}), 32'd0);

    do_read(4'd5, mk(1'b0, 4'd5, 4'd0, 8'h00, 8'h00));

    do_write(4'd3, 8'hA5, 8'hFF, 4'h7, 1'b1);
    do_lookup(8'hA5, mk(1'b1, 4'd3, 4'h7, 8'h00, 8'h00));
    chk("lookup_cnt_1", 32'(lookup_cnt), 32'd1);
    chk("hit_cnt_1", 32'(hit_cnt), 32'd1);

    do_write(4'd2, 8'hA0, 8'hF0, 4'h9, 1'b1);
    do_lookup(8'hA5, mk(1'b1, 4'd2, 4'h9, 8'h00, 8'h00));
    do_lookup(8'h5A, mk(1'b0, 4'd0, 4'h0, 8'h00, 8'h00));
    chk("lookup_cnt_3", 32'(lookup_cnt), 32'd3);
    chk("hit_cnt_miss_unchanged", 32'(hit_cnt), 32'd2);

    // Backpressure: response held with rsp_ready low, a stray command is ignored
    rsp_ready = 1'b0;
    sb.push_back(mk(1'b1, 4'd2, 4'h9, 8'h00, 8'h00));
    issue(OP_LOOKUP, '0, 8'hA5, '0, '0, 1'b0);
    @(posedge clk); #1;
    snap = {rsp_hit, rsp_index, rsp_id, rsp_key, rsp_mask};
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 4'd0; cmd_key = 8'h5A;
        cmd_mask = 8'hFF; cmd_id = 4'h1; cmd_vld = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_fields_stable", 32'({rsp_hit, rsp_index, rsp_id, rsp_key, rsp_mask}), 32'(snap));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp_done();
    do_lookup(8'h5A, mk(1'b0, 4'd0, 4'h0, 8'h00, 8'h00));
    chk("lookup_cnt_5", 32'(lookup_cnt), 32'd5);
    chk("hit_cnt_3", 32'(hit_cnt), 32'd3);

    do_write(4'd10, 8'h00, 8'h00, 4'h3, 1'b1);
    do_lookup(8'h5A, mk(1'b1, 4'd10, 4'h3, 8'h00, 8'h00));

    issue(OP_FLUSH, '0, '0, '0, '0, 1'b0);
    do_lookup(8'hA5, mk(1'b0, 4'd0, 4'h0, 8'h00, 8'h00));
    do_read(4'd3, mk(1'b0, 4'd3, 4'h7, 8'hA5, 8'hFF));
    chk("lookup_cnt_7", 32'(lookup_cnt), 32'd7);
    chk("hit_cnt_4", 32'(hit_cnt), 32'd4);

    // Saturation with a 4-bit counter build
    do_write(4'd0, 8'h00, 8'h00, 4'h1, 1'b1);
    for (int i = 0; i < 7; i++) do_lookup(8'h33, mk(1'b1, 4'd0, 4'h1, 8'h00, 8'h00));
    chk("lookup_cnt_14", 32'(lookup_cnt), 32'd14);
    chk("hit_cnt_11", 32'(hit_cnt), 32'd11);
    for (int i = 0; i < 5; i++) do_lookup(8'h33, mk(1'b1, 4'd0, 4'h1, 8'h00, 8'h00));
    chk("lookup_cnt_sat", 32'(lookup_cnt), 32'd15);
    chk("hit_cnt_sat", 32'(hit_cnt), 32'd15);

    // Reset while a response is pending
    rsp_ready = 1'b0;
    issue(OP_LOOKUP, '0, 8'h33, '0, '0, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_counters", 32'({lookup_cnt, hit_cnt}), 32'd0);
    chk("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    do_read(4'd0, mk(1'b0, 4'd0, 4'h0, 8'h00, 8'h00));

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
